// File: rtl/rca_pkg.sv
// Shared definitions for the time-multiplexed wide ripple-carry adder:
// datapath width, controller states and operation codes.
package rca_pkg;

    localparam int RCA_WIDTH = 32;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell used to build the ripple-carry chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca_32bit_cin.sv
// 32-bit ripple-carry adder with carry-in, a chain of full-adder cells.
module rca_32bit_cin
    import rca_pkg::*;
(
    input  logic [RCA_WIDTH-1:0] a,
    input  logic [RCA_WIDTH-1:0] b,
    input  logic                 cin,
    output logic                 cout,
    output logic [RCA_WIDTH-1:0] sout
);

    logic [RCA_WIDTH:0] carry;

    assign carry[0] = cin;

    for (genvar i = 0; i < RCA_WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (carry[i]),
            .s    (sout[i]),
            .cout (carry[i+1])
        );
    end

    assign cout = carry[RCA_WIDTH];

endmodule

// File: rtl/rca_wide_add_seq.sv
// WORDS x 32-bit add/sub unit that walks one shared 32-bit RCA over the
// operands least-significant word first, chaining the carry through a register.
module rca_wide_add_seq
    import rca_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       op_sub,
    input  logic                       abort,
    input  logic [RCA_WIDTH*WORDS-1:0] a,
    input  logic [RCA_WIDTH*WORDS-1:0] b,
    output logic                       busy,
    output logic                       done,
    output logic [RCA_WIDTH*WORDS-1:0] sum,
    output logic                       cout,
    output logic                       ovf
);

    localparam int W     = RCA_WIDTH * WORDS;
    localparam int IDX_W = $clog2(WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_t state, next_state;

    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic             op_q;
    logic [IDX_W-1:0] idx;
    logic             carry;

    logic load, step, finish;

    logic [RCA_WIDTH-1:0] a_word, b_raw, b_word, word_sum;
    logic                 word_cout;

    assign a_word = a_q[idx*RCA_WIDTH +: RCA_WIDTH];
    assign b_raw  = b_q[idx*RCA_WIDTH +: RCA_WIDTH];
    assign b_word = (op_q == OP_ADD) ? b_raw : ~b_raw;

    rca_32bit_cin u_rca (
        .a    (a_word),
        .b    (b_word),
        .cin  (carry),
        .cout (word_cout),
        .sout (word_sum)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                // abort wins over the word update, including the final one
                if (abort) begin
                    next_state = IDLE;
                end else begin
                    step = 1'b1;
                    if (idx == LAST_IDX) begin
                        finish     = 1'b1;
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= OP_ADD;
            idx   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= finish;
            if (load) begin
                a_q   <= a;
                b_q   <= b;
                op_q  <= op_sub;
                idx   <= '0;
                // subtraction is A + ~B + 1, the +1 enters as the first carry-in
                carry <= (op_sub == OP_SUB);
            end
            if (step) begin
                sum[idx*RCA_WIDTH +: RCA_WIDTH] <= word_sum;
                carry <= word_cout;
                idx   <= idx + 1'b1;
            end
            if (finish) begin
                cout <= word_cout;
                ovf  <= (a_word[RCA_WIDTH-1] == b_word[RCA_WIDTH-1]) &&
                        (word_sum[RCA_WIDTH-1] != a_word[RCA_WIDTH-1]);
            end
        end
    end

    assign busy = (state == RUN);

endmodule

// File: tb/tb_rca_wide_add_seq.sv
// Self-checking bench for rca_wide_add_seq (WORDS=4) with a result scoreboard.
module tb_rca_wide_add_seq;

    localparam int WORDS = 4;
    localparam int W     = 32 * WORDS;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         op_sub;
    logic         abort;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    rca_wide_add_seq #(.WORDS(WORDS)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op_sub (op_sub),
        .abort  (abort),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic sub);
        exp_t       e;
        logic [W:0] r;
        if (!sub) r = {1'b0, av} + {1'b0, bv};
        else      r = {1'b0, av} + {1'b0, ~bv} + (W+1)'(1);
        e.sum  = r[W-1:0];
        e.cout = r[W];
        if (!sub) e.ovf = (av[W-1] == bv[W-1]) && (r[W-1] != av[W-1]);
        else      e.ovf = (av[W-1] != bv[W-1]) && (r[W-1] != av[W-1]);
        return e;
    endfunction

    // Drive a request from a post-edge point; returns 1 time unit after the accept edge.
    task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                         input logic sub, input bit track);
        a      = av;
        b      = bv;
        op_sub = sub;
        start  = 1'b1;
        if (track) sb.push_back(model(av, bv, sub));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic compare_result(input string name);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s: done with empty scoreboard", name);
            return;
        end
        e = sb.pop_front();
        if (sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
            bad++;
            $display("FAIL %s: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                     name, sum, cout, ovf, e.sum, e.cout, e.ovf);
        end
    endtask

    task automatic wait_done(input string name, input int lat);
        int n   = 0;
        bit got = 0;
        while (n < 20 && !got) begin
            @(posedge clk); #1;
            n++;
            if (done) got = 1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL %s_timeout: no done within %0d edges", name, n);
            void'(sb.pop_front());
            return;
        end
        total++;
        if (n != lat || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_latency: got %0d edges busy=%b want %0d edges busy=0",
                     name, n, busy, lat);
        end
        compare_result(name);
    endtask

    task automatic check_idle_zero(input string name);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL %s: got busy=%b done=%b sum=%h cout=%b ovf=%b want all zero",
                     name, busy, done, sum, cout, ovf);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        check_idle_zero("reset_held");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_idle_zero("reset_released");
    endtask

    task automatic test_add();
        issue(W'(32'h0C), W'(32'h02), 1'b0, 1'b1);
        wait_done("add_0c_02", WORDS);
        issue(W'(32'h03), W'(32'h03), 1'b0, 1'b1);
        wait_done("add_03_03", WORDS);
    endtask

    task automatic test_carry_ripple();
        int n   = 0;
        bit got = 0;
        issue({W{1'b1}}, W'(1), 1'b0, 1'b1);
        for (int k = 1; k < WORDS; k++) begin
            @(posedge clk); #1;
            n++;
            total++;
            if (dut.carry !== 1'b1 || busy !== 1'b1) begin
                bad++;
                $display("FAIL ripple_carry_word%0d: got carry=%b busy=%b want carry=1 busy=1",
                         k, dut.carry, busy);
            end
        end
        while (n < 20 && !got) begin
            @(posedge clk); #1;
            n++;
            if (done) got = 1;
        end
        total++;
        if (!got || n != WORDS) begin
            bad++;
            $display("FAIL ripple_latency: got done=%b after %0d edges want done after %0d",
                     got, n, WORDS);
        end
        compare_result("ripple_result");
    endtask

    task automatic test_sub();
        issue(W'(32'h03), W'(32'h0C), 1'b1, 1'b1);
        wait_done("sub_borrow", WORDS);
        issue(W'(32'h0C), W'(32'h03), 1'b1, 1'b1);
        wait_done("sub_no_borrow", WORDS);
    endtask

    task automatic test_overflow();
        issue({1'b0, {(W-1){1'b1}}}, W'(1), 1'b0, 1'b1);
        wait_done("ovf_add", WORDS);
        issue({1'b1, {(W-1){1'b0}}}, W'(1), 1'b1, 1'b1);
        wait_done("ovf_sub", WORDS);
    endtask

    task automatic test_start_held();
        int dones = 0;
        a      = W'(32'h1234_5678) << 40;
        b      = W'(32'hFFFF_0000);
        op_sub = 1'b0;
        start  = 1'b1;
        sb.push_back(model(a, b, 1'b0));
        // keep start high through the accept edge and three RUN edges
        repeat (WORDS) begin
            @(posedge clk); #1;
        end
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (done) begin
                dones++;
                compare_result("start_held_result");
            end
        end
        total++;
        if (dones != 1) begin
            bad++;
            $display("FAIL start_held_done_count: got %0d want 1", dones);
        end
    endtask

    task automatic test_back_to_back();
        issue(W'(32'h0000_0100), W'(32'h0000_0011), 1'b0, 1'b1);
        wait_done("b2b_first", WORDS);
        issue({W{1'b1}}, W'(32'h5), 1'b1, 1'b1);
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            bad++;
            $display("FAIL b2b_accept: got busy=%b done=%b want busy=1 done=0", busy, done);
        end
        wait_done("b2b_second", WORDS);
    endtask

    task automatic test_abort();
        bit seen = 0;
        issue(W'(32'h0C), W'(32'h02), 1'b0, 1'b0);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL abort_exit: got busy=%b done=%b want busy=0 done=0", busy, done);
        end
        repeat (6) begin
            @(posedge clk); #1;
            if (done) seen = 1;
        end
        total++;
        if (seen) begin
            bad++;
            $display("FAIL abort_no_done: got done pulse want none");
        end
        // abort while idle must not block the request
        abort = 1'b1;
        issue(W'(32'h0C), W'(32'h03), 1'b1, 1'b1);
        abort = 1'b0;
        wait_done("abort_in_idle", WORDS);
    endtask

    task automatic test_reset_mid_run();
        issue(W'(32'h0C), W'(32'h03), 1'b0, 1'b0);
        @(posedge clk); #1;
        total++;
        if (sum[31:0] !== 32'h0F) begin
            bad++;
            $display("FAIL midrun_word0: got %h want 0000000f", sum[31:0]);
        end
        @(posedge clk); #1;
        #3;
        rst_n = 1'b0;
        #1;
        check_idle_zero("reset_mid_run");
        #7;
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(W'(32'h0C), W'(32'h03), 1'b0, 1'b1);
        wait_done("after_reset_add", WORDS);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        op_sub = 1'b0;
        abort  = 1'b0;
        a      = '0;
        b      = '0;
        test_reset();
        test_add();
        test_carry_ripple();
        test_sub();
        test_overflow();
        test_start_held();
        test_back_to_back();
        test_abort();
        test_reset_mid_run();
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
